// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Iteration counter width; must be able to hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic             shift_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] new_rem,
    output logic             quo_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // part_rem < divisor always holds, so the MSB of trial is a clean borrow flag.
    always_comb begin
        shifted = {part_rem, shift_bit};
        trial   = shifted - {1'b0, divisor};
        quo_bit = ~trial[WIDTH];
        new_rem = quo_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider with pipeline stall/flush handshake.
// Define DIV_SIGNED_EN to add the signed_op port and signed (truncating) division.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             div_stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int            CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] dvnd_mag;
    logic [WIDTH-1:0] dvsr_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] final_quo;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;
    logic             accept;
    logic             finish;
    logic             zero_div;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .part_rem (acc),
        .shift_bit(quo_work[WIDTH-1]),
        .divisor  (dvsr),
        .new_rem  (step_rem),
        .quo_bit  (step_bit)
    );

    assign final_quo = (quo_work << 1) | WIDTH'(step_bit);
    assign zero_div  = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic neg_quo;
    logic neg_rem;

    assign dvnd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvsr_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            neg_quo <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem <= signed_op & dividend[WIDTH-1];
        end
    end

    // Most-negative / -1 needs no special case: negating the magnitude wraps back.
    assign res_quo = neg_quo ? -final_quo : final_quo;
    assign res_rem = neg_rem ? -step_rem  : step_rem;
`else
    assign dvnd_mag = dividend;
    assign dvsr_mag = divisor;
    assign res_quo  = final_quo;
    assign res_rem  = step_rem;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new divide may start while the previous done is showing, so there is no bubble.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        div_stall  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done       = (state == DONE);
                next_state = IDLE;
                if (start && !flush) begin
                    accept     = 1'b1;
                    div_stall  = 1'b1;
                    next_state = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                div_stall = 1'b1;
                if (flush) begin
                    next_state = IDLE;
                end else if (count == '0) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Results only move on a completed divide, so a flush leaves the last answer visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            acc         <= '0;
            quo_work    <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count    <= LAST_STEP;
            acc      <= '0;
            quo_work <= dvnd_mag;
            dvsr     <= dvsr_mag;
            if (zero_div) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            acc      <= step_rem;
            quo_work <= final_quo;
            count    <= count - CW'(1);
            if (finish) begin
                quotient    <= res_quo;
                remainder   <= res_rem;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: arithmetic reference model plus directed literal cases.
module tb_div_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         div_stall;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    div_sequencer #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef DIV_SIGNED_EN
        .signed_op  (signed_op),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .div_stall  (div_stall),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: tracks only "busy for N more edges" and the arithmetic answer.
    bit           m_busy = 1'b0;
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] pend_q = '0;
    logic [W-1:0] pend_r = '0;
    logic [W-1:0] exp_q  = '0;
    logic [W-1:0] exp_r  = '0;
    bit           exp_dbz = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_left  = 0;
            m_done  = 1'b0;
            exp_q   = '0;
            exp_r   = '0;
            exp_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy  = 1'b0;
                        m_done  = 1'b1;
                        exp_q   = pend_q;
                        exp_r   = pend_r;
                        exp_dbz = 1'b0;
                    end
                end
            end else if (start && !flush) begin
                if (divisor == '0) begin
                    m_done  = 1'b1;
                    exp_q   = '1;
                    exp_r   = dividend;
                    exp_dbz = 1'b1;
                end else begin
                    int sa;
                    int sb;
                    int qi;
                    int ri;
                    bit sgn;
`ifdef DIV_SIGNED_EN
                    sgn = signed_op;
`else
                    sgn = 1'b0;
`endif
                    if (sgn) begin
                        sa = int'($signed(dividend));
                        sb = int'($signed(divisor));
                    end else begin
                        sa = int'({16'd0, dividend});
                        sb = int'({16'd0, divisor});
                    end
                    qi     = sa / sb;
                    ri     = sa % sb;
                    pend_q = qi[W-1:0];
                    pend_r = ri[W-1:0];
                    m_busy = 1'b1;
                    m_left = W;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        check_output("stall", {31'd0, div_stall}, {31'd0, m_busy || (start && !flush)});
        check_output("done", {31'd0, done}, {31'd0, m_done});
        check_output("quotient", {16'd0, quotient}, {16'd0, exp_q});
        check_output("remainder", {16'd0, remainder}, {16'd0, exp_r});
        check_output("div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dbz});
    end

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = sop;
        start     = 1'b1;
    endtask

    // Counts edges from the accepting edge (edge 1) until done is seen, bounded.
    task automatic wait_done(input int max_cycles, output int lat);
        lat = 0;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        repeat (3) @(negedge clk);
        #3;
        check_output("rst_quotient", {16'd0, quotient}, 32'h0);
        check_output("rst_remainder", {16'd0, remainder}, 32'h0);
        check_output("rst_done", {31'd0, done}, 32'h0);
        check_output("rst_stall_idle", {31'd0, div_stall}, 32'h0);
        start = 1'b1;
        #1;
        check_output("rst_stall_start", {31'd0, div_stall}, 32'h1);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;

        apply_stimulus(16'd100, 16'd7, 1'b0);
        wait_done(40, lat);
        check_output("lat_100_7", lat, 32'd17);
        check_output("q_100_7", {16'd0, quotient}, 32'd14);
        check_output("r_100_7", {16'd0, remainder}, 32'd2);
        check_output("dbz_100_7", {31'd0, div_by_zero}, 32'd0);
        check_output("stall_in_done", {31'd0, div_stall}, 32'd0);

        apply_stimulus(16'd5, 16'd0, 1'b0);
        wait_done(40, lat);
        check_output("lat_5_0", lat, 32'd1);
        check_output("q_5_0", {16'd0, quotient}, 32'hFFFF);
        check_output("r_5_0", {16'd0, remainder}, 32'd5);
        check_output("dbz_5_0", {31'd0, div_by_zero}, 32'd1);

        apply_stimulus(16'd20, 16'd6, 1'b0);
        wait_done(40, lat);
        check_output("q_20_6", {16'd0, quotient}, 32'd3);
        dividend = 16'd9;
        divisor  = 16'd4;
        start    = 1'b1;
        wait_done(40, lat);
        check_output("lat_b2b", lat, 32'd17);
        check_output("q_9_4", {16'd0, quotient}, 32'd2);
        check_output("r_9_4", {16'd0, remainder}, 32'd1);

        apply_stimulus(16'd50, 16'd5, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_output("flush_stall", {31'd0, div_stall}, 32'd0);
        count_dones(25, n);
        check_output("flush_no_done", n, 32'd0);
        check_output("flush_q_held", {16'd0, quotient}, 32'd2);
        check_output("flush_r_held", {16'd0, remainder}, 32'd1);

`ifdef DIV_SIGNED_EN
        apply_stimulus(16'hFFF9, 16'd2, 1'b1);
        wait_done(40, lat);
        check_output("q_m7_2", {16'd0, quotient}, 32'hFFFD);
        check_output("r_m7_2", {16'd0, remainder}, 32'hFFFF);
        apply_stimulus(16'h8000, 16'hFFFF, 1'b1);
        wait_done(40, lat);
        check_output("lat_ovf", lat, 32'd17);
        check_output("q_ovf", {16'd0, quotient}, 32'h8000);
        check_output("r_ovf", {16'd0, remainder}, 32'h0);
        signed_op = 1'b0;
`endif

        apply_stimulus(16'd77, 16'd3, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #3;
        check_output("midrst_q", {16'd0, quotient}, 32'd0);
        check_output("midrst_r", {16'd0, remainder}, 32'd0);
        check_output("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        count_dones(25, n);
        check_output("midrst_no_done", n, 32'd0);
        apply_stimulus(16'd12, 16'd3, 1'b0);
        wait_done(40, lat);
        check_output("lat_12_3", lat, 32'd17);
        check_output("q_12_3", {16'd0, quotient}, 32'd4);
        check_output("r_12_3", {16'd0, remainder}, 32'd0);

        // Random traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 599) != 0);
            start = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1, 2:    divisor = W'($urandom_range(1, 15));
                3:       divisor = 16'hFFFF;
                default: divisor = W'($urandom);
            endcase
            dividend = ($urandom_range(0, 15) == 0) ? 16'h8000 : W'($urandom);
`ifdef DIV_SIGNED_EN
            signed_op = $urandom_range(0, 1) == 1;
`else
            signed_op = 1'b0;
`endif
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        repeat (25) @(negedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 start  in  1  execute stage presents a divide; sampled only when accepting.
REQ-005 signed_op  in  1  1 = signed divide; port present only with DIV_SIGNED_EN.
REQ-006 dividend  in  WIDTH  numerator, sampled on accepted start.
REQ-007 divisor  in  WIDTH  denominator, sampled on accepted start.
REQ-008 flush  in  1  abort in-flight divide (branch/jump squash).
REQ-009 div_stall  out  1  freeze upstream pipeline while result not ready.
REQ-010 done  out  1  one-cycle pulse; quotient/remainder valid.
REQ-011 quotient  out  WIDTH  result quotient, held until next done.
REQ-012 remainder  out  WIDTH  result remainder, held until next done.
REQ-013 div_by_zero  out  1  set with done when divisor was 0, held with results.

Function
REQ-014 FSM states IDLE, CALC, DONE shall be used; IDLE after reset.
REQ-015 Start accepted in IDLE or DONE when start=1 and flush=0; operands latched; next state CALC, iteration counter = WIDTH-1.
REQ-016 CALC performs one restoring shift-subtract step per cycle; after WIDTH steps (counter reaching 0) next state DONE.
REQ-017 Latency: done asserts exactly WIDTH+1 cycles after the accepting edge (17 for WIDTH=16).
REQ-018 div_stall = (start & (IDLE|DONE) & ~flush) | CALC, combinational; low in the done cycle.
REQ-019 DONE lasts one cycle, done=1, then IDLE unless a new start is accepted (back-to-back allowed, no bubble).
REQ-020 start while in CALC shall be ignored.
REQ-021 Divisor 0: skip CALC, go directly to DONE next cycle; quotient all-ones, remainder = dividend, div_by_zero=1.
REQ-022 flush in CALC or DONE: next state IDLE, no done pulse, quotient/remainder/div_by_zero keep prior values; flush has priority over start.
REQ-023 Unsigned mode: quotient = floor(dividend/divisor), remainder = dividend - quotient*divisor, WIDTH-bit results.

Reset
REQ-024 rst low shall immediately force IDLE, counter 0, quotient 0, remainder 0, div_by_zero 0, done 0; div_stall depends only on start/flush.
REQ-025 Reset mid-CALC shall abandon the operation with no done after release.

Configuration
REQ-026 Macro DIV_SIGNED_EN defined: signed_op present; signed_op=1 takes magnitudes, divides unsigned, truncates toward zero; remainder sign = dividend sign; most-negative / -1 yields quotient 0x8000 (WIDTH=16), remainder 0; latency unchanged.
REQ-027 DIV_SIGNED_EN undefined: signed_op port absent, all divides unsigned, no sign-fix logic.

Structure
REQ-028 Shared package div_pkg shall hold state enum (IDLE, CALC, DONE) and DIV_WIDTH constant (16).
REQ-029 One sub-module div_step (combinational single restoring step: partial remainder, quotient bit) shall be instantiated inside.

Verification
REQ-030 Unsigned 100/7 -> done 17 cycles after accept, quotient 14, remainder 2, div_by_zero 0; div_stall high 17 cycles incl. start cycle.
REQ-031 5/0 -> done 1 cycle after accept, quotient 0xFFFF, remainder 5, div_by_zero 1.
REQ-032 Start 50/5, flush at cycle 5 of CALC -> no done, div_stall low next cycle, outputs keep previous values.
REQ-033 Back-to-back: start 9/4 in DONE cycle of prior divide -> second done 17 cycles later, quotient 2, remainder 1.
REQ-034 DIV_SIGNED_EN: -7/2 -> quotient 0xFFFD, remainder 0xFFFF; 0x8000/0xFFFF -> quotient 0x8000, remainder 0.
REQ-035 rst low at CALC cycle 8 -> outputs 0, IDLE, no done after release; new 12/3 then gives quotient 4, remainder 0.
